// File: rtl/dmem_bus_ctrl.sv
// Data-memory bus controller between the MEM stage and a req/gnt/rvalid bus.
// Runs one access at a time and stalls the pipeline until it completes.
module dmem_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_re_i,
  input  logic [3:0]  mem_we_i,
  input  logic [31:0] mem_raddr_i,
  input  logic [31:0] mem_waddr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        bus_req_o,
  output logic [31:0] bus_addr_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             store;
  logic             access;
  logic             tmo;
  logic             complete;
  logic             abort;

  assign store  = |mem_we_i;
  assign access = mem_re_i | store;
  assign tmo    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next state, stall and completion/abort decisions.
  always_comb begin
    state_d  = state_q;
    stall_o  = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_o = access;
        if (access) state_d = REQ;
      end
      REQ: begin
        stall_o = 1'b1;
        if (bus_gnt_i && bus_rvalid_i) begin
          complete = 1'b1;
          state_d  = DONE;
        end else if (tmo) begin
          abort   = 1'b1;
          state_d = DONE;
        end else if (bus_gnt_i) begin
          state_d = RESP;
        end
      end
      RESP: begin
        stall_o = 1'b1;
        if (bus_rvalid_i) begin
          complete = 1'b1;
          state_d  = DONE;
        end else if (tmo) begin
          abort   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, bus request registers, timeout counter and returned data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_req_o   <= 1'b0;
      bus_addr_o  <= '0;
      bus_we_o    <= 1'b0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
      mem_rdata_o <= '0;
      err_o       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q <= state_d;
      err_o   <= 1'b0;
      if (state_q == IDLE && access) begin
        bus_req_o <= 1'b1;
        cnt_q     <= '0;
        if (store) begin
          bus_addr_o  <= {mem_waddr_i[31:2], 2'b00};
          bus_we_o    <= 1'b1;
          bus_be_o    <= mem_we_i;
          bus_wdata_o <= mem_wdata_i;
        end else begin
          bus_addr_o  <= {mem_raddr_i[31:2], 2'b00};
          bus_we_o    <= 1'b0;
          bus_be_o    <= 4'b1111;
          bus_wdata_o <= '0;
        end
      end
      if (state_q == REQ || state_q == RESP) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (state_q == REQ && bus_gnt_i) begin
        bus_req_o <= 1'b0;
      end
      if (complete) begin
        err_o <= bus_err_i;
        if (bus_err_i || bus_we_o) mem_rdata_o <= '0;
        else mem_rdata_o <= bus_rdata_i;
      end
      if (abort) begin
        bus_req_o   <= 1'b0;
        mem_rdata_o <= '0;
        err_o       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// Directed bench for dmem_bus_ctrl: loads, stores, wait states,
// same-cycle response, timeout, bus error and reset mid-access.
module tb_dmem_bus_ctrl;

  logic        clk;
  logic        rst;
  logic        mem_re_i;
  logic [3:0]  mem_we_i;
  logic [31:0] mem_raddr_i;
  logic [31:0] mem_waddr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        stall_o;
  logic        err_o;
  logic        bus_req_o;
  logic [31:0] bus_addr_o;
  logic        bus_we_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [31:0] bus_rdata_i;
  logic        bus_err_i;

  int total = 0;
  int bad = 0;
  int stall_cnt = 0;
  int n;

  dmem_bus_ctrl #(
    .TIMEOUT_CYCLES(8),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_re_i(mem_re_i),
    .mem_we_i(mem_we_i),
    .mem_raddr_i(mem_raddr_i),
    .mem_waddr_i(mem_waddr_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o),
    .stall_o(stall_o),
    .err_o(err_o),
    .bus_req_o(bus_req_o),
    .bus_addr_o(bus_addr_o),
    .bus_we_o(bus_we_o),
    .bus_be_o(bus_be_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i(bus_rdata_i),
    .bus_err_i(bus_err_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (stall_o) stall_cnt++;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_re_i     = 1'b0;
    mem_we_i     = 4'b0000;
    mem_raddr_i  = '0;
    mem_waddr_i  = '0;
    mem_wdata_i  = '0;
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
    bus_err_i    = 1'b0;
  endtask

  task automatic quick_load(input logic [31:0] a, input logic [31:0] d);
    stall_cnt   = 0;
    mem_re_i    = 1'b1;
    mem_raddr_i = a;
    #1;
    tick();
    bus_gnt_i    = 1'b1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = d;
    #1;
    tick();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    #1;
    chk("ql_rdata", mem_rdata_o, d);
    chk("ql_err", err_o, 0);
    chk("ql_stall_done", stall_o, 0);
    mem_re_i = 1'b0;
    tick();
    chk("ql_stalls", stall_cnt, 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_req", bus_req_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_rdata", mem_rdata_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_stall", stall_o, 0);
    rst = 1'b0;
    tick();

    // zero-wait load
    stall_cnt   = 0;
    mem_re_i    = 1'b1;
    mem_raddr_i = 32'h0000_1006;
    #1;
    chk("t1_stall_idle", stall_o, 1);
    tick();
    bus_gnt_i = 1'b1;
    #1;
    chk("t1_req", bus_req_o, 1);
    chk("t1_addr", bus_addr_o, 32'h0000_1004);
    chk("t1_be", bus_be_o, 4'b1111);
    chk("t1_we", bus_we_o, 0);
    chk("t1_wdata", bus_wdata_o, 0);
    tick();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hDEAD_BEEF;
    #1;
    chk("t1_req_resp", bus_req_o, 0);
    chk("t1_stall_resp", stall_o, 1);
    tick();
    bus_rvalid_i = 1'b0;
    #1;
    chk("t1_rdata", mem_rdata_o, 32'hDEAD_BEEF);
    chk("t1_err", err_o, 0);
    chk("t1_stall_done", stall_o, 0);
    mem_re_i = 1'b0;
    tick();
    chk("t1_no_reissue", bus_req_o, 0);
    chk("t1_stalls", stall_cnt, 3);
    chk("t1_rdata_hold", mem_rdata_o, 32'hDEAD_BEEF);

    // byte store with delayed grant
    stall_cnt   = 0;
    mem_we_i    = 4'b0100;
    mem_waddr_i = 32'h0000_2002;
    mem_wdata_i = 32'h00AB_0000;
    bus_rdata_i = 32'h5555_5555;
    #1;
    chk("t2_stall_idle", stall_o, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      bus_gnt_i = (i == 4);
      #1;
      chk("t2_req", bus_req_o, 1);
      chk("t2_addr", bus_addr_o, 32'h0000_2000);
      chk("t2_we", bus_we_o, 1);
      chk("t2_be", bus_be_o, 4'b0100);
      chk("t2_wdata", bus_wdata_o, 32'h00AB_0000);
      tick();
    end
    bus_gnt_i = 1'b0;
    #1;
    chk("t2_req_resp", bus_req_o, 0);
    chk("t2_stall_resp", stall_o, 1);
    tick();
    bus_rvalid_i = 1'b1;
    #1;
    tick();
    bus_rvalid_i = 1'b0;
    #1;
    chk("t2_stall_done", stall_o, 0);
    chk("t2_rdata", mem_rdata_o, 0);
    chk("t2_err", err_o, 0);
    idle_in();
    tick();
    chk("t2_stalls", stall_cnt, 8);

    // gnt and rvalid together
    quick_load(32'h0000_3000, 32'h1234_5678);

    // timeout: grant never arrives
    stall_cnt   = 0;
    mem_re_i    = 1'b1;
    mem_raddr_i = 32'h0000_4000;
    #1;
    tick();
    n = 0;
    while (bus_req_o && n < 20) begin
      n++;
      tick();
    end
    chk("t4_req_cycles", n, 8);
    chk("t4_err", err_o, 1);
    chk("t4_rdata", mem_rdata_o, 0);
    chk("t4_stall_done", stall_o, 0);
    mem_re_i = 1'b0;
    tick();
    chk("t4_err_pulse", err_o, 0);
    bus_rvalid_i = 1'b1;
    bus_err_i    = 1'b1;
    bus_rdata_i  = 32'hAAAA_AAAA;
    tick();
    idle_in();
    #1;
    chk("t4_stray_err", err_o, 0);
    chk("t4_stray_rdata", mem_rdata_o, 0);
    chk("t4_stray_req", bus_req_o, 0);
    chk("t4_stray_stall", stall_o, 0);
    chk("t4_stalls", stall_cnt, 9);

    // bus error on load
    quick_load(32'h0000_5008, 32'h0BAD_F00D);
    mem_re_i    = 1'b1;
    mem_raddr_i = 32'h0000_5000;
    #1;
    tick();
    bus_gnt_i = 1'b1;
    #1;
    tick();
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b1;
    bus_err_i    = 1'b1;
    bus_rdata_i  = 32'hFFFF_FFFF;
    #1;
    tick();
    idle_in();
    mem_re_i = 1'b1;
    #1;
    chk("t5_rdata", mem_rdata_o, 0);
    chk("t5_err", err_o, 1);
    mem_re_i = 1'b0;
    tick();
    chk("t5_err_pulse", err_o, 0);

    // reset during RESP, then late rvalid, then store+load
    quick_load(32'h0000_6004, 32'h7777_7777);
    mem_re_i    = 1'b1;
    mem_raddr_i = 32'h0000_6000;
    #1;
    tick();
    bus_gnt_i = 1'b1;
    #1;
    tick();
    bus_gnt_i = 1'b0;
    mem_re_i  = 1'b0;
    rst       = 1'b1;
    #1;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_req", bus_req_o, 0);
    chk("t6_addr", bus_addr_o, 0);
    chk("t6_be", bus_be_o, 0);
    chk("t6_rdata", mem_rdata_o, 0);
    chk("t6_err", err_o, 0);
    chk("t6_stall", stall_o, 0);
    tick();
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h0000_0099;
    tick();
    bus_rvalid_i = 1'b0;
    #1;
    chk("t6_late_err", err_o, 0);
    chk("t6_late_rdata", mem_rdata_o, 0);
    chk("t6_late_req", bus_req_o, 0);
    chk("t6_late_stall", stall_o, 0);
    mem_re_i    = 1'b1;
    mem_raddr_i = 32'h0000_8000;
    mem_we_i    = 4'b0011;
    mem_waddr_i = 32'h0000_7000;
    mem_wdata_i = 32'h0000_BEEF;
    #1;
    chk("t6_st_stall", stall_o, 1);
    tick();
    chk("t6_st_we", bus_we_o, 1);
    chk("t6_st_addr", bus_addr_o, 32'h0000_7000);
    chk("t6_st_be", bus_be_o, 4'b0011);
    chk("t6_st_wdata", bus_wdata_o, 32'h0000_BEEF);
    bus_gnt_i    = 1'b1;
    bus_rvalid_i = 1'b1;
    tick();
    idle_in();
    tick();
    chk("t6_st_idle", bus_req_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
